reg_access_ctrl: RTL
====================

// Module: reg_access_ctrl
// PURPOSE
//  Initiator side of the 16x16 register bank interface: operand-fetch / writeback sequencer.
//  Accepts decoded instructions (srcA, srcB, dst), drives the bank read ports and returns operands to execute.
//  Arbitrates writebacks onto the bank write port, and tracks pending destinations in a scoreboard (RAW/WAW stall).
//  Forwards same-cycle writeback data, because bank reads are combinational and bank writes land on the posedge.
// PARAMETERS
//  DATA_W  16  register width; bit 0 is MSB ([0:DATA_W-1] ordering throughout)
//  ADDR_W  4   register address width
//  NREGS   16  number of registers (2**ADDR_W)
// PORTS
//  clk         in   1       single clock, all state on posedge
//  reset       in   1       synchronous, active-high
//  iss_valid   in   1       issue request valid
//  iss_ready   out  1       issue accepted this cycle when iss_valid & iss_ready (iss_fire)
//  iss_srcA    in   ADDR_W  source A register
//  iss_srcB    in   ADDR_W  source B register
//  iss_dst     in   ADDR_W  destination register
//  iss_wen     in   1       instruction will write iss_dst
//  rf_read     out  1       bank read strobe (= iss_valid & ~reset)
//  rf_rdAddrA  out  ADDR_W  = iss_srcA
//  rf_rdDataA  in   DATA_W  bank port A data (combinational)
//  rf_rdAddrB  out  ADDR_W  = iss_srcB
//  rf_rdDataB  in   DATA_W  bank port B data
//  rf_write    out  1       bank write enable (= wb_fire)
//  rf_wrAddr   out  ADDR_W  = wb_addr
//  rf_wrData   out  DATA_W  = wb_data
//  wb_valid    in   1       writeback result valid
//  wb_ready    out  1       = ~reset; wb_fire = wb_valid & wb_ready
//  wb_addr     in   ADDR_W  writeback register
//  wb_data     in   DATA_W  writeback value
//  op_valid    out  1       operand bundle valid (registered)
//  op_ready    in   1       execute consumes bundle when op_valid & op_ready
//  op_A, op_B  out  DATA_W  operands
//  op_dst      out  ADDR_W  forwarded iss_dst
//  op_wen      out  1       forwarded iss_wen
// BEHAVIOUR
//  - Reset: busy[0:NREGS-1]=0, op_valid=0, op_A=op_B=0, op_dst=0, op_wen=0; while reset=1, rf_write=0, wb_ready=0, iss_ready=0.
//  - slot_free = ~op_valid | op_ready.
//  - srcX_ok = ~busy[srcX] | (wb_fire & wb_addr==srcX).
//  - dst_ok = ~iss_wen | ~busy[dst] | (wb_fire & wb_addr==dst).
//  - iss_ready = slot_free & srcA_ok & srcB_ok & dst_ok & ~reset. This is combinational from the iss_* fields.
//  - Operand select: if wb_fire & wb_addr==srcX, take wb_data (bypass); otherwise take rf_rdDataX.
//  - Latency: iss_fire at cycle N -> op_valid=1 with the bundle at cycle N+1.
//  - op_* hold stable while op_valid & ~op_ready. Consume without a new fire -> op_valid=0 next cycle.
//  - Scoreboard update, per cycle:
//    - wb_fire clears busy[wb_addr].
//    - iss_fire & iss_wen sets busy[iss_dst].
//    - If both hit the same register, set wins.
//  - Register 0 is not special.
//  - Writeback to a non-busy register is still written to the bank; the scoreboard is unchanged.
//  - srcA==srcB and src==dst are legal. Operands are the pre-issue values; busy[dst] is set afterwards.
//  - Reset mid-operation: the in-flight bundle is dropped and all busy bits are cleared. A writeback presented during reset is not written.
// STRUCTURE
//  - Package reg_access_pkg:
//    - DATA_W, ADDR_W, NREGS constants.
//    - typedefs reg_addr_t, reg_data_t.
//    - struct op_bundle_t {A, B, dst, wen}.
//  - Sub-module reg_scoreboard holds the busy vector: set/clear ports, set-wins priority, two source lookups plus one dst lookup.
//  - Top module holds: bypass muxes, iss_ready logic, and the op_bundle_t output register.
// TESTING
//  1. Preload r3=0x1234, r5=0x00FF; issue srcA=3, srcB=5, dst=1, wen=1 -> next cycle op_valid=1, op_A=0x1234, op_B=0x00FF, busy[1]=1.
//  2. RAW: busy[2]=1; issue srcA=2 -> iss_ready=0. wb r2=0xBEEF in cycle K -> fire at K, op_A=0xBEEF at K+1, bank r2=0xBEEF.
//  3. Backpressure: op_ready=0 for 3 cycles with op_valid=1 -> op_* unchanged, iss_ready=0. op_ready=1 -> pending issue fires the same cycle.
//  4. WAW: busy[7]=1; issue dst=7 wen=1 stalls. wb_addr=7 in the same cycle -> issue fires, busy[7] remains 1.
//  5. Self-reference: r4=0x0042 not busy; issue srcA=srcB=dst=4 -> op_A=op_B=0x0042, busy[4]=1 after.
//  6. Reset mid-op: busy={1,7} set, op_valid=1, wb_valid=1 -> assert reset 1 cycle -> rf_write=0; next cycle busy=0, op_valid=0, all op_* are 0.

Source files
------------

// File: rtl/reg_access_pkg.sv
// Shared widths, types and the operand bundle carried from operand fetch to execute.
package reg_access_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [0:DATA_W-1] reg_data_t;

  typedef struct packed {
    reg_data_t A;
    reg_data_t B;
    reg_addr_t dst;
    logic      wen;
  } op_bundle_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy vector for pending destinations; a set and a clear to the same register
// in one cycle leaves it busy.
module reg_scoreboard
  import reg_access_pkg::*;
#(
  parameter int NREGS  = reg_access_pkg::NREGS,
  parameter int ADDR_W = reg_access_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_lkA_addr,
  input  logic [ADDR_W-1:0] i_lkB_addr,
  input  logic [ADDR_W-1:0] i_lkD_addr,
  output logic              o_busyA,
  output logic              o_busyB,
  output logic              o_busyD
);
  logic [0:NREGS-1] r_busy;

  // Set is applied after clear so it takes priority on a shared address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (i_clr) r_busy[i_clr_addr] <= 1'b0;
      if (i_set) r_busy[i_set_addr] <= 1'b1;
    end
  end

  assign o_busyA = r_busy[i_lkA_addr];
  assign o_busyB = r_busy[i_lkB_addr];
  assign o_busyD = r_busy[i_lkD_addr];
endmodule

// File: rtl/reg_access_ctrl.sv
// Operand-fetch / writeback sequencer in front of a register bank with
// combinational reads; same-cycle writebacks are bypassed into the operands.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int DATA_W = reg_access_pkg::DATA_W,
  parameter int ADDR_W = reg_access_pkg::ADDR_W,
  parameter int NREGS  = reg_access_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] iss_srcA,
  input  logic [ADDR_W-1:0] iss_srcB,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic              iss_wen,
  output logic              rf_read,
  output logic [ADDR_W-1:0] rf_rdAddrA,
  input  logic [0:DATA_W-1] rf_rdDataA,
  output logic [ADDR_W-1:0] rf_rdAddrB,
  input  logic [0:DATA_W-1] rf_rdDataB,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wrAddr,
  output logic [0:DATA_W-1] rf_wrData,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [0:DATA_W-1] wb_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [0:DATA_W-1] op_A,
  output logic [0:DATA_W-1] op_B,
  output logic [ADDR_W-1:0] op_dst,
  output logic              op_wen
);
  logic       w_wb_fire, w_iss_fire, w_slot_free;
  logic       w_busyA, w_busyB, w_busyD;
  logic       w_fwdA, w_fwdB, w_fwdD;
  logic       w_srcA_ok, w_srcB_ok, w_dst_ok;
  op_bundle_t w_next;
  op_bundle_t r_op;
  logic       r_op_valid;

  assign w_wb_fire = wb_valid & ~reset;
  assign wb_ready  = ~reset;

  assign rf_read    = iss_valid & ~reset;
  assign rf_rdAddrA = iss_srcA;
  assign rf_rdAddrB = iss_srcB;
  assign rf_write   = w_wb_fire;
  assign rf_wrAddr  = wb_addr;
  assign rf_wrData  = wb_data;

  reg_scoreboard #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_set      (w_iss_fire & iss_wen),
    .i_set_addr (iss_dst),
    .i_clr      (w_wb_fire),
    .i_clr_addr (wb_addr),
    .i_lkA_addr (iss_srcA),
    .i_lkB_addr (iss_srcB),
    .i_lkD_addr (iss_dst),
    .o_busyA    (w_busyA),
    .o_busyB    (w_busyB),
    .o_busyD    (w_busyD)
  );

  // A writeback landing this cycle resolves the hazard it would otherwise cause.
  assign w_fwdA = w_wb_fire & (wb_addr == iss_srcA);
  assign w_fwdB = w_wb_fire & (wb_addr == iss_srcB);
  assign w_fwdD = w_wb_fire & (wb_addr == iss_dst);

  assign w_srcA_ok   = ~w_busyA | w_fwdA;
  assign w_srcB_ok   = ~w_busyB | w_fwdB;
  assign w_dst_ok    = ~iss_wen | ~w_busyD | w_fwdD;
  assign w_slot_free = ~r_op_valid | op_ready;

  assign iss_ready  = w_slot_free & w_srcA_ok & w_srcB_ok & w_dst_ok & ~reset;
  assign w_iss_fire = iss_valid & iss_ready;

  always_comb begin
    w_next     = '0;
    w_next.A   = w_fwdA ? wb_data : rf_rdDataA;
    w_next.B   = w_fwdB ? wb_data : rf_rdDataB;
    w_next.dst = iss_dst;
    w_next.wen = iss_wen;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_valid <= 1'b0;
      r_op       <= '0;
    end else if (w_iss_fire) begin
      r_op_valid <= 1'b1;
      r_op       <= w_next;
    end else if (op_ready) begin
      r_op_valid <= 1'b0;
    end
  end

  assign op_valid = r_op_valid;
  assign op_A     = r_op.A;
  assign op_B     = r_op.B;
  assign op_dst   = r_op.dst;
  assign op_wen   = r_op.wen;
endmodule
